// File: rtl/fpu_mul_exception_resolver_if.sv
// Handshake and payload bundle between the multiplier exception detector,
// the exception resolver and the downstream result consumer.
interface fpu_mul_exception_resolver_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_man;
  logic        in_invalid;
  logic        in_overflow;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_man, in_invalid, in_overflow, in_zero,
    output out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_man, in_invalid, in_overflow, in_zero,
    input  out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fpu_mul_exception_resolver.sv
// Resolves multiplier exception flags into IEEE-754 single-precision special
// results behind a one-deep valid/ready stage, with sticky status, counters and irq.
module fpu_mul_exception_resolver #(
  parameter int unsigned CNT_W = 8,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpu_mul_exception_resolver_if.slave bus,
  input  logic [2:0]           irq_en,
  input  logic                 clear_status,
  output logic [2:0]           status_sticky,
  output logic [CNT_W-1:0]     cnt_invalid,
  output logic [CNT_W-1:0]     cnt_overflow,
  output logic [CNT_W-1:0]     cnt_zero,
  output logic                 irq
);

  localparam int unsigned RES_W  = 32;
  localparam int unsigned FLAG_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              out_valid_q;
  logic [RES_W-1:0]  out_result_q;
  logic [FLAG_W-1:0] out_flags_q;

  logic              accept;
  logic [FLAG_W-1:0] in_flags;
  logic [RES_W-1:0]  result_d;

  logic [FLAG_W-1:0] sticky_d;
  logic [CNT_W-1:0]  cnt_inv_d;
  logic [CNT_W-1:0]  cnt_ovf_d;
  logic [CNT_W-1:0]  cnt_zero_d;
  logic              irq_d;

  // Single output register: a new beat may enter whenever the slot drains this cycle.
  assign bus.in_ready   = !out_valid_q || bus.out_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign in_flags = {bus.in_invalid, bus.in_overflow, bus.in_zero};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    sat_inc = (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  // Special-result substitution, invalid > overflow > zero > raw product.
  always_comb begin
    result_d = {bus.in_sign, bus.in_exp, bus.in_man};
    if (bus.in_invalid) begin
      result_d = QNAN;
    end else if (bus.in_overflow) begin
      result_d = {bus.in_sign, 8'hFF, 23'h0};
    end else if (bus.in_zero) begin
      result_d = {bus.in_sign, 31'h0};
    end
  end

  // Status update: clear takes effect first, then the accepted beat is folded in.
  always_comb begin
    sticky_d   = clear_status ? '0 : status_sticky;
    cnt_inv_d  = clear_status ? '0 : cnt_invalid;
    cnt_ovf_d  = clear_status ? '0 : cnt_overflow;
    cnt_zero_d = clear_status ? '0 : cnt_zero;
    irq_d      = clear_status ? 1'b0 : irq;
    if (accept) begin
      sticky_d   = sticky_d | in_flags;
      cnt_inv_d  = sat_inc(cnt_inv_d,  bus.in_invalid);
      cnt_ovf_d  = sat_inc(cnt_ovf_d,  bus.in_overflow);
      cnt_zero_d = sat_inc(cnt_zero_d, bus.in_zero);
      irq_d      = irq_d || ((in_flags & irq_en) != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_result_q <= result_d;
      out_flags_q  <= in_flags;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_sticky <= '0;
      cnt_invalid   <= '0;
      cnt_overflow  <= '0;
      cnt_zero      <= '0;
      irq           <= 1'b0;
    end else begin
      status_sticky <= sticky_d;
      cnt_invalid   <= cnt_inv_d;
      cnt_overflow  <= cnt_ovf_d;
      cnt_zero      <= cnt_zero_d;
      irq           <= irq_d;
    end
  end

endmodule

// File: doc/fpu_mul_exception_resolver.md
Name: fpu_mul_exception_resolver

Overview:
- Consumer side of the multiplier exception-flag interface.
- Accepts the raw packed product plus the invalid/overflow/zero flags produced by the multiplier's exception detector.
- Substitutes IEEE-754 single-precision special results, registers the final result behind a valid/ready output stage, and keeps sticky status flags, saturating event counters and a maskable interrupt for the FPU status/control logic.

Parameters:
- CNT_W, 8, width of each per-flag saturating event counter.
- QNAN, 32'h7FC00000, canonical quiet NaN driven on invalid.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  raw product and flags valid.
- in_ready  output  1  block can accept the input this cycle.
- in_sign  input  1  product sign (sx XOR sy).
- in_exp  input  8  raw product exponent.
- in_man  input  23  raw product mantissa.
- in_invalid  input  1  invalid flag from the exception detector.
- in_overflow  input  1  overflow flag from the exception detector.
- in_zero  input  1  zero flag from the exception detector.
- out_valid  output  1  final result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  32  final IEEE-754 single-precision result.
- out_flags  output  3  {invalid, overflow, zero} attached to out_result.
- irq_en  input  3  interrupt enable per flag, same bit order as out_flags.
- clear_status  input  1  one-cycle pulse; clears sticky flags, counters and irq.
- status_sticky  output  3  sticky OR of all accepted flags since the last clear.
- cnt_invalid, cnt_overflow, cnt_zero  output  CNT_W each  accepted-event counts, saturating.
- irq  output  1  level interrupt.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_result=0, out_flags=0, status_sticky=0, all counters 0, irq=0. An in-flight result is discarded. in_ready=1 from the first cycle after release.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single output register).
  - Input accepted when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - Latency: exactly 1 cycle, accept at edge N gives out_valid high after edge N.
  - Back-to-back full throughput when out_ready is held high.
  - While out_valid && !out_ready: out_result and out_flags hold stable, and in_ready=0.
  - out_valid clears only on a transfer with no simultaneous accept.
- Result substitution, priority order, registered at accept:
  - in_invalid: result=QNAN, sign ignored.
  - else in_overflow: result={in_sign, 8'hFF, 23'h0}.
  - else in_zero: result={in_sign, 31'h0}.
  - else: result={in_sign, in_exp, in_man}.
  - out_flags registers the raw three input flags unmodified. Several flags may be set simultaneously; all are reported.
- Sticky status: on accept, status_sticky <= status_sticky | {inv, ovf, zero}.
- Counters: on accept, each counter whose flag is set increments by 1. A counter at 2^CNT_W-1 holds; there is no wrap.
- irq:
  - Set on an accept where (flags & irq_en) != 0.
  - Stays high until clear_status.
  - Changing irq_en never clears irq and never raises it retroactively.
- clear_status: at the next edge, zeroes status_sticky, counters and irq. It does not affect out_valid, out_result or out_flags.
- Simultaneous clear_status and accept: the clear applies first, then the accepted flags are applied. Result: sticky = new flags, counters = 1 for each set flag, irq set if the new flags are enabled.
- Inputs are ignored when in_valid=0 or in_ready=0. Flags of a non-accepted beat never touch status.

Test Plan:
- Normal product: in={0, 8'h7F, 23'h0}, no flags, out_ready=1 -> one cycle later out_result=32'h3F800000, out_flags=0, sticky=0.
- Special results:
  - in_invalid=1 with in_overflow=1 and in_sign=1 -> out_result=32'h7FC00000, out_flags=3'b110, cnt_invalid=1, cnt_overflow=1.
  - in_overflow only, sign=1 -> 32'hFF800000.
  - in_zero only, sign=1 -> 32'h80000000.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0, out_result stable, no counter change. Release -> first result transfers, next input accepted the same cycle, counters incremented once per beat.
- Saturation: CNT_W=2, 5 accepted overflow beats -> cnt_overflow=3. clear_status -> 0, sticky=0.
- irq: irq_en=3'b010, zero beat -> irq=0. Overflow beat -> irq=1. Irq stays high after irq_en=0. clear_status in the same cycle as an overflow accept -> irq=1, cnt_overflow=1.
- Reset mid-operation: assert rst_n low asynchronously while out_valid=1 with out_ready=0 -> out_valid, sticky, counters and irq all 0 immediately; a normal beat after release passes with 1-cycle latency.
